// File: rtl/clock_pkg.sv
// Shared encodings for the digital-clock time path: controller states and
// blink-mask bit positions used by the controller and the display scanner.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_e;

  localparam int MASK_HOUR = 2;
  localparam int MASK_MIN  = 1;
  localparam int MASK_SEC  = 0;

  // Digit pair to blank for a given state and blink phase.
  function automatic logic [2:0] blink_for(state_e st, logic phase);
    logic [2:0] m;
    m = 3'b000;
    case (st)
      ST_SET_HOUR: m[MASK_HOUR] = phase;
      ST_SET_MIN:  m[MASK_MIN]  = phase;
      default:     m[MASK_SEC]  = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// 1 Hz prescaler: counts 0..CLK_HZ-1, registered terminal strobe, blink phase.
// zero_i restarts the count so the following second is a full one.
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic zero_i,
  output logic tick_o,
  output logic term_o,
  output logic blink_phase_d_o
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_HZ / 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  // term_o is the value tick_o takes after this edge; blink_phase_d_o is the
  // phase of the count after this edge, so callers can register it in step.
  always_comb begin
    term_o = (cnt_q == LAST) && !zero_i;
    if (zero_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    blink_phase_d_o = (cnt_d >= HALF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= term_o;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/clock_time_ctrl.sv
// Time-path controller: 1 Hz base, carry chaining in RUN, button-driven
// hour/minute setting and blink masks for the seven-segment scanner.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       sec_co,
  input  logic       min_co,
  input  logic       hour_co,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic       sec_clr,
  output logic       tick_1hz,
  output logic       day_pulse,
  output logic [1:0] mode,
  output logic [2:0] blink_mask
);

  state_e     state_q, state_d;
  logic       run_prev_q;
  logic       sec_en_q, sec_en_d;
  logic       min_en_q, min_en_d;
  logic       hour_en_q, hour_en_d;
  logic       sec_clr_q, sec_clr_d;
  logic       day_q, day_d;
  logic [2:0] mask_q, mask_d;

  logic load_zero;
  logic term;
  logic phase_d;
  logic carry_ok;
  logic inc_ok;

  tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk             (clk),
    .rst             (rst),
    .zero_i          (load_zero),
    .tick_o          (tick_1hz),
    .term_o          (term),
    .blink_phase_d_o (phase_d)
  );

  always_comb begin
    state_d = state_q;
    if (mode_btn) begin
      case (state_q)
        ST_RUN:      state_d = ST_SET_HOUR;
        ST_SET_HOUR: state_d = ST_SET_MIN;
        default:     state_d = ST_RUN;
      endcase
    end
  end

  // Carries count only in steady RUN: rollovers caused by manual increments,
  // or arriving as set mode is entered or left, are discarded.
  always_comb begin
    load_zero = (state_q == ST_SET_MIN) && mode_btn;
    carry_ok  = (state_q == ST_RUN) && run_prev_q && (state_d == ST_RUN);
    inc_ok    = inc_btn && !mode_btn;

    sec_en_d  = (state_d == ST_RUN) && term;
    min_en_d  = (carry_ok && sec_co) || ((state_q == ST_SET_MIN) && inc_ok);
    hour_en_d = (carry_ok && min_co) || ((state_q == ST_SET_HOUR) && inc_ok);
    day_d     = carry_ok && hour_co;
    sec_clr_d = (state_q == ST_RUN) && (state_d == ST_SET_HOUR);
    mask_d    = blink_for(state_d, phase_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      run_prev_q <= 1'b0;
      sec_en_q   <= 1'b0;
      min_en_q   <= 1'b0;
      hour_en_q  <= 1'b0;
      sec_clr_q  <= 1'b0;
      day_q      <= 1'b0;
      mask_q     <= 3'b000;
    end else begin
      state_q    <= state_d;
      run_prev_q <= (state_q == ST_RUN);
      sec_en_q   <= sec_en_d;
      min_en_q   <= min_en_d;
      hour_en_q  <= hour_en_d;
      sec_clr_q  <= sec_clr_d;
      day_q      <= day_d;
      mask_q     <= mask_d;
    end
  end

  assign sec_en     = sec_en_q;
  assign min_en     = min_en_q;
  assign hour_en    = hour_en_q;
  assign sec_clr    = sec_clr_q;
  assign day_pulse  = day_q;
  assign mode       = state_q;
  assign blink_mask = mask_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with CLK_HZ=10: vector table for the
// FSM/carry gating plus hand sequences using behavioural BCD counter models.
module tb_clock_time_ctrl;

  localparam int HZ = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       sec_co, min_co, hour_co;
  logic       sec_en, min_en, hour_en, sec_clr, tick_1hz, day_pulse;
  logic [1:0] mode;
  logic [2:0] blink_mask;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  clock_time_ctrl #(.CLK_HZ(HZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_btn   (mode_btn),
    .inc_btn    (inc_btn),
    .sec_co     (sec_co),
    .min_co     (min_co),
    .hour_co    (hour_co),
    .sec_en     (sec_en),
    .min_en     (min_en),
    .hour_en    (hour_en),
    .sec_clr    (sec_clr),
    .tick_1hz   (tick_1hz),
    .day_pulse  (day_pulse),
    .mode       (mode),
    .blink_mask (blink_mask)
  );

  // Carry inputs come from the vector table or from the counter models.
  logic use_model = 1'b0;
  logic t_sec_co = 1'b0, t_min_co = 1'b0, t_hour_co = 1'b0;
  logic m_sec_co = 1'b0, m_min_co = 1'b0, m_hour_co = 1'b0;
  int   secs = 0, mins = 0, hours = 0;
  logic load_req = 1'b0;
  int   ld_s = 0, ld_m = 0, ld_h = 0;

  assign sec_co  = use_model ? m_sec_co  : t_sec_co;
  assign min_co  = use_model ? m_min_co  : t_min_co;
  assign hour_co = use_model ? m_hour_co : t_hour_co;

  always @(posedge clk) begin
    if (load_req) begin
      secs <= ld_s; mins <= ld_m; hours <= ld_h;
      m_sec_co <= 1'b0; m_min_co <= 1'b0; m_hour_co <= 1'b0;
    end else begin
      if (sec_clr) secs <= 0;
      else if (sec_en) secs <= (secs == 59) ? 0 : secs + 1;
      m_sec_co <= sec_en && !sec_clr && (secs == 59);
      if (min_en) mins <= (mins == 59) ? 0 : mins + 1;
      m_min_co <= min_en && (mins == 59);
      if (hour_en) hours <= (hours == 23) ? 0 : hours + 1;
      m_hour_co <= hour_en && (hours == 23);
    end
  end

  typedef struct {
    logic       mb, ib, sc, mc, hc;
    logic [1:0] e_mode;
    logic       e_clr, e_min, e_hour, e_day;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Steps until tick_1hz is seen; returns steps taken (limit if never seen).
  task automatic steps_to_tick(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick_1hz && n < limit);
  endtask

  initial begin
    int n;
    logic hour_seen;
    logic [5:0] act6, exp6;
    logic [6:0] act7, exp7;

    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held 3 cycles: everything low, RUN.
    repeat (3) step();
    act7 = {mode, blink_mask, sec_en, min_en, hour_en} | {5'b0, sec_clr, tick_1hz | day_pulse};
    chk("reset_outputs", int'(act7), 0);
    rst = 1'b0;
    steps_to_tick(15, n);
    chk("first_tick_cycles", n, 10);
    chk("first_sec_en", int'(sec_en), 1);
    steps_to_tick(15, n);
    chk("second_tick_cycles", n, 10);
    $display("reset/tick cadence checked, mode=%0d", mode);

    // Vector table: FSM transitions and carry gating with direct carries.
    step();
    for (int i = 0; i < 14; i++) begin
      mode_btn = vecs[i].mb; inc_btn = vecs[i].ib;
      t_sec_co = vecs[i].sc; t_min_co = vecs[i].mc; t_hour_co = vecs[i].hc;
      step();
      act6 = {mode, sec_clr, min_en, hour_en, day_pulse};
      exp6 = {vecs[i].e_mode, vecs[i].e_clr, vecs[i].e_min, vecs[i].e_hour, vecs[i].e_day};
      chk($sformatf("vec%0d", i), int'(act6), int'(exp6));
      if (vecs[i].e_mode != 2'd0) chk($sformatf("vec%0d_sec_en", i), int'(sec_en), 0);
      $display("vec %0d: mode=%0d clr=%b min_en=%b hour_en=%b day=%b",
               i, mode, sec_clr, min_en, hour_en, day_pulse);
    end
    mode_btn = 1'b0; inc_btn = 1'b0;
    t_sec_co = 1'b0; t_min_co = 1'b0; t_hour_co = 1'b0;
    step();

    // Run chain from 23:59:59 with counter models.
    use_model = 1'b1;
    ld_s = 59; ld_m = 59; ld_h = 23; load_req = 1'b1;
    step();
    load_req = 1'b0;
    n = 0;
    while (!sec_en && n < 15) begin step(); n++; end
    chk("chain_sec_en_seen", int'(sec_en), 1);
    step(); chk("chain_min_en_early", int'(min_en), 0);
    step(); chk("chain_min_en", int'(min_en), 1);
    step(); chk("chain_min_en_once", int'(min_en), 0);
    step(); chk("chain_hour_en", int'(hour_en), 1);
    step(); chk("chain_day_early", int'(day_pulse), 0);
    step(); chk("chain_day_pulse", int'(day_pulse), 1);
    step(); chk("chain_day_once", int'(day_pulse), 0);
    chk("chain_time", secs * 10000 + mins * 100 + hours, 0);
    $display("run chain: time now %0d:%0d:%0d", hours, mins, secs);

    // Set hour: synchronise on a tick so prescaler phase is known.
    steps_to_tick(15, n);
    chk("sync_tick_seen", int'(tick_1hz), 1);
    mode_btn = 1'b1;
    step();
    mode_btn = 1'b0;
    chk("set_hour_entry", int'({mode, sec_clr, blink_mask}), int'({2'd1, 1'b1, 3'b000}));
    ld_s = 0; ld_m = 0; ld_h = 23;
    for (int i = 2; i <= 31; i++) begin
      load_req = (i == 2);
      inc_btn  = (i == 3);
      step();
      act7 = {blink_mask, sec_en, day_pulse, hour_en, sec_clr};
      exp7 = {((i % 10) >= 5) ? 3'b100 : 3'b000, 1'b0, 1'b0, (i == 3), 1'b0};
      chk($sformatf("set_hour_c%0d", i), int'(act7), int'(exp7));
    end
    load_req = 1'b0; inc_btn = 1'b0;
    chk("set_hour_wrapped", hours, 0);
    chk("set_hour_mode", int'(mode), 1);
    $display("set hour: hours=%0d mode=%0d", hours, mode);

    // Set minute wrap, staying in SET_MIN.
    mode_btn = 1'b1; step(); mode_btn = 1'b0;
    chk("set_min_mode", int'(mode), 2);
    ld_s = 0; ld_m = 59; ld_h = 0; load_req = 1'b1; step(); load_req = 1'b0;
    inc_btn = 1'b1; step(); inc_btn = 1'b0;
    chk("set_min_en", int'(min_en), 1);
    step();
    chk("set_min_wrapped", mins, 0);
    hour_seen = 1'b0;
    repeat (3) begin step(); hour_seen |= hour_en; end
    chk("set_min_no_hour_en", int'(hour_seen), 0);

    // Same wrap, but leave to RUN as the carry arrives.
    ld_m = 59; load_req = 1'b1; step(); load_req = 1'b0;
    inc_btn = 1'b1; step(); inc_btn = 1'b0;
    chk("exit_min_en", int'(min_en), 1);
    mode_btn = 1'b1; step(); mode_btn = 1'b0;
    chk("exit_first_run", int'({mode, blink_mask, sec_en, hour_en}), 0);
    hour_seen = 1'b0;
    n = 0;
    do begin step(); n++; hour_seen |= hour_en; end while (!sec_en && n < 15);
    chk("exit_first_sec_en", n, 10);
    chk("exit_no_hour_en", int'(hour_seen), 0);
    chk("exit_time", hours * 100 + mins, 0);
    $display("exit to run: first sec_en after %0d cycles", n);

    // Simultaneous mode_btn + inc_btn in SET_HOUR.
    mode_btn = 1'b1; step();
    chk("simul_enter", int'(mode), 1);
    inc_btn = 1'b1; step(); mode_btn = 1'b0; inc_btn = 1'b0;
    chk("simul_mode", int'({mode, hour_en, min_en}), int'({2'd2, 1'b0, 1'b0}));
    step();
    chk("simul_after", int'({hour_en, min_en}), 0);
    $display("simultaneous buttons: mode=%0d", mode);

    // Reset while blinking in SET_MIN.
    n = 0;
    while (blink_mask != 3'b010 && n < 15) begin step(); n++; end
    chk("mid_blink_seen", int'(blink_mask), 2);
    rst = 1'b1; step(); rst = 1'b0;
    act7 = {mode, blink_mask, sec_en, min_en, hour_en} | {5'b0, sec_clr, tick_1hz | day_pulse};
    chk("mid_reset_outputs", int'(act7), 0);
    steps_to_tick(15, n);
    chk("mid_reset_tick_cycles", n, 10);
    chk("mid_reset_sec_en", int'(sec_en), 1);
    $display("reset mid-set: tick after %0d cycles, mode=%0d", n, mode);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
